// File: rtl/hls_run_sequencer.sv
// Sequences one load / start / run / read-back cycle of the HLS `main` accelerator over slave channel 0.
// Optional run watchdog is enabled by defining RUN_TIMEOUT_EN.
module hls_run_sequencer #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 64,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  run_done,
  output logic [1:0]            run_status,
  output logic [CNT_W-1:0]      run_cycles,
  output logic                  accel_stuck,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*ADDR_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy
);

  typedef enum logic [2:0] {IDLE, WR, START, RUN, FIN, RD, RSP} state_t;

  localparam logic [ADDR_W-1:0] BYTE_SIZE = ADDR_W'(8);

  state_t             state;
  logic               ready_en;
  logic               last_q;
  logic [CNT_W-1:0]   counter;
  logic               oe0;
  logic               we0;
  logic [ADDR_W-1:0]  addr0;
  logic [7:0]         wdata0;
  logic [ADDR_W-1:0]  size0;
  logic               ld_fire;
  logic               rd_fire;
  logic               unused_inputs;
  localparam int      UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  // ready_en keeps both readies low while reset is held and for the first edge after release
  assign ld_ready = (state == IDLE) && ready_en && !accel_stuck;
  assign rd_ready = ld_ready && !ld_valid;
  assign ld_fire  = ld_valid && ld_ready;
  assign rd_fire  = rd_valid && rd_ready;

  assign S_oe_ram        = {1'b0, oe0};
  assign S_we_ram        = {1'b0, we0};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr0};
  assign S_Wdata_ram     = {{(2*DATA_W-8){1'b0}}, wdata0};
  assign S_data_ram_size = {{ADDR_W{1'b0}}, size0};
  assign unused_inputs   = ^{Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};

`ifndef RUN_TIMEOUT_EN
  assign accel_stuck = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      last_q     <= 1'b0;
      counter    <= '0;
      oe0        <= 1'b0;
      we0        <= 1'b0;
      addr0      <= '0;
      wdata0     <= '0;
      size0      <= '0;
      start_port <= 1'b0;
      run_done   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      run_status <= 2'b00;
      run_cycles <= '0;
`ifdef RUN_TIMEOUT_EN
      accel_stuck <= 1'b0;
`endif
    end else begin
      ready_en   <= 1'b1;
      start_port <= 1'b0;
      run_done   <= 1'b0;
      rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_fire) begin
            state  <= WR;
            we0    <= 1'b1;
            addr0  <= ld_addr;
            wdata0 <= ld_data;
            size0  <= BYTE_SIZE;
            last_q <= ld_last;
          end else if (rd_fire) begin
            state <= RD;
            oe0   <= 1'b1;
            addr0 <= rd_addr;
            size0 <= BYTE_SIZE;
          end
        end
        WR: begin
          if (Sout_DataRdy[0]) begin
            we0    <= 1'b0;
            addr0  <= '0;
            wdata0 <= '0;
            size0  <= '0;
            if (last_q) begin
              state      <= START;
              start_port <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        START: begin
          counter <= '0;
          state   <= RUN;
        end
        RUN: begin
          // run_cycles counts the sampling cycle too, so a done in the first RUN cycle reports 1
          if (done_port) begin
            run_cycles <= (counter == '1) ? counter : counter + 1'b1;
            run_status <= 2'b00;
            run_done   <= 1'b1;
            state      <= FIN;
`ifdef RUN_TIMEOUT_EN
          end else if (counter == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            run_cycles  <= CNT_W'(TIMEOUT_CYCLES);
            run_status  <= 2'b10;
            accel_stuck <= 1'b1;
            run_done    <= 1'b1;
            state       <= FIN;
`endif
          end else if (counter != '1) begin
            counter <= counter + 1'b1;
          end
        end
        FIN: state <= IDLE;
        RD: begin
          if (Sout_DataRdy[0]) begin
            oe0       <= 1'b0;
            addr0     <= '0;
            size0     <= '0;
            rsp_data  <= Sout_Rdata_ram[7:0];
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Randomized self-checking bench for hls_run_sequencer; acts as host and as the accelerator's slave memory.
module tb_hls_run_sequencer;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam int TMO    = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic                ld_valid, ld_ready, ld_last, rd_valid, rd_ready;
  logic [ADDR_W-1:0]   ld_addr, rd_addr;
  logic [7:0]          ld_data, rsp_data;
  logic                rsp_valid, run_done, accel_stuck, start_port, done_port;
  logic [1:0]          run_status, S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [CNT_W-1:0]    run_cycles;
  logic [2*ADDR_W-1:0] S_addr_ram, S_data_ram_size;
  logic [2*DATA_W-1:0] S_Wdata_ram, Sout_Rdata_ram;

  logic [7:0] ref_mem   [128];
  logic [7:0] slave_mem [128];
  int checks = 0;
  int errors = 0;

  localparam logic [2*ADDR_W-1:0] EXP_SIZE = (2*ADDR_W)'(8);

  always #5 clock = ~clock;

  hls_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .run_done(run_done), .run_status(run_status), .run_cycles(run_cycles), .accel_stuck(accel_stuck),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  task automatic test_reset();
    reset = 1'b0; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_last = 0;
    rd_valid = 0; rd_addr = 0; done_port = 0; Sout_DataRdy = 0; Sout_Rdata_ram = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    #2;
    checks++;
    if ({ld_ready, rd_ready, rsp_valid, rsp_data, run_done, run_status, run_cycles, accel_stuck, start_port,
         S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: some output nonzero during reset (ld_ready=%b rd_ready=%b we=%b oe=%b cycles=%0d)",
               ld_ready, rd_ready, S_we_ram, S_oe_ram, run_cycles);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ld_ready, rd_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 11", {ld_ready, rd_ready});
    end
  endtask

  // Writes one byte; the bench's slave memory accepts after lat extra cycles
  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic last, input int lat);
    int b = 0;
    logic [2*DATA_W-1:0] exp_wdata;
    exp_wdata = '0; exp_wdata[7:0] = d;
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
    #1;
    while (!ld_ready && b < 20) begin
      @(negedge clock); #1; b++;
    end
    if (b == 20) begin
      checks++; errors++;
      $display("[TB] FAIL load_ready_timeout: ld_ready=%b expected 1", ld_ready);
    end
    @(posedge clock);
    @(negedge clock);
    ld_valid = 0; ld_last = 0;
    ref_mem[a] = d;
    for (int c = 0; c <= lat; c++) begin
      checks++;
      if ({S_we_ram, S_oe_ram, S_addr_ram, S_data_ram_size, S_Wdata_ram, ld_ready} !==
          {2'b01, 2'b00, {ADDR_W{1'b0}}, a, EXP_SIZE, exp_wdata, 1'b0}) begin
        errors++;
        $display("[TB] FAIL load_bus c=%0d: got we=%b oe=%b addr=%h size=%h wdata=%h rdy=%b expected we=01 addr=%h data=%h rdy=0",
                 c, S_we_ram, S_oe_ram, S_addr_ram, S_data_ram_size, S_Wdata_ram, ld_ready, a, d);
      end
      if (c == lat) begin
        Sout_DataRdy = 2'b01;
        slave_mem[S_addr_ram[ADDR_W-1:0]] = S_Wdata_ram[7:0];
      end else begin
        Sout_DataRdy = {1'b1, 1'b0};
      end
      @(negedge clock);
    end
    Sout_DataRdy = 2'b00;
    checks++;
    if ({S_we_ram, start_port} !== {2'b00, last}) begin
      errors++;
      $display("[TB] FAIL load_end: got we=%b start=%b expected we=00 start=%b", S_we_ram, start_port, last);
    end
  endtask

  // Entered at the START-cycle negedge; done_port is seen in RUN cycle d
  task automatic do_run(input int d);
    for (int k = 1; k <= d; k++) begin
      @(negedge clock);
      checks++;
      if ({start_port, run_done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL run_idle k=%0d: got start=%b done=%b expected 0 0", k, start_port, run_done);
      end
      if (k == d) done_port = 1'b1;
    end
    @(negedge clock);
    done_port = 1'b0;
    checks++;
    if ({run_done, run_status, run_cycles, accel_stuck} !== {1'b1, 2'b00, CNT_W'(d), 1'b0}) begin
      errors++;
      $display("[TB] FAIL run_result: got done=%b status=%b cycles=%0d stuck=%b expected 1 00 %0d 0",
               run_done, run_status, run_cycles, accel_stuck, d);
    end
    @(negedge clock);
    checks++;
    if ({run_done, ld_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL run_after: got done=%b ld_ready=%b expected 0 1", run_done, ld_ready);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int lat);
    int b = 0;
    rd_valid = 1; rd_addr = a;
    #1;
    while (!rd_ready && b < 20) begin
      @(negedge clock); #1; b++;
    end
    if (b == 20) begin
      checks++; errors++;
      $display("[TB] FAIL read_ready_timeout: rd_ready=%b expected 1", rd_ready);
    end
    @(posedge clock);
    @(negedge clock);
    rd_valid = 0;
    for (int c = 0; c <= lat; c++) begin
      checks++;
      if ({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, rsp_valid} !==
          {2'b01, 2'b00, {ADDR_W{1'b0}}, a, EXP_SIZE, 1'b0}) begin
        errors++;
        $display("[TB] FAIL read_bus c=%0d: got oe=%b we=%b addr=%h size=%h rsp=%b expected oe=01 addr=%h",
                 c, S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, rsp_valid, a);
      end
      Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
      if (c == lat) begin
        Sout_Rdata_ram[7:0] = slave_mem[S_addr_ram[ADDR_W-1:0]];
        Sout_DataRdy = 2'b01;
      end else begin
        Sout_DataRdy = 2'b10;
      end
      @(negedge clock);
    end
    Sout_DataRdy = 2'b00;
    checks++;
    if ({rsp_valid, rsp_data, S_oe_ram} !== {1'b1, ref_mem[a], 2'b00}) begin
      errors++;
      $display("[TB] FAIL read_rsp: got valid=%b data=%h oe=%b expected 1 %h 00", rsp_valid, rsp_data, S_oe_ram, ref_mem[a]);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_pulse: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_single_load();
    do_load(7'd3, 8'hA5, 1'b1, 0);
    do_run(10);
  endtask

  task automatic test_delayed_loads();
    for (int i = 0; i < 4; i++)
      do_load(7'($urandom), 8'($urandom), i == 3, 3);
    do_run($urandom_range(1, 20));
  endtask

  task automatic test_read_after_run();
    ref_mem[5] = 8'h3C;
    slave_mem[5] = 8'h3C;
    do_read(7'd5, 2);
  endtask

  task automatic test_simultaneous();
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
    a = 7'($urandom); d = 8'($urandom);
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = 0;
    rd_valid = 1; rd_addr = a;
    #1;
    checks++;
    if ({ld_ready, rd_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL both_valid_ready: got %b expected 10", {ld_ready, rd_ready});
    end
    @(posedge clock);
    @(negedge clock);
    ld_valid = 0;
    ref_mem[a] = d;
    checks++;
    if ({S_we_ram, S_oe_ram, rd_ready} !== {2'b01, 2'b00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL both_valid_wr: got we=%b oe=%b rd_ready=%b expected 01 00 0", S_we_ram, S_oe_ram, rd_ready);
    end
    slave_mem[S_addr_ram[ADDR_W-1:0]] = S_Wdata_ram[7:0];
    Sout_DataRdy = 2'b01;
    @(negedge clock);
    Sout_DataRdy = 2'b00;
    do_read(a, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 2) begin
        if ($urandom_range(0, 3) == 0) begin
          do_load(7'($urandom), 8'($urandom), 1'b1, $urandom_range(0, 3));
          do_run($urandom_range(1, 25));
        end else begin
          do_load(7'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3));
        end
      end else begin
        do_read(7'($urandom), $urandom_range(0, 3));
      end
    end
  endtask

`ifdef RUN_TIMEOUT_EN
  task automatic test_timeout();
    do_load(7'($urandom), 8'($urandom), 1'b1, 0);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clock);
      checks++;
      if (run_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_early k=%0d: got run_done=%b expected 0", k, run_done);
      end
    end
    @(negedge clock);
    checks++;
    if ({run_done, run_status, run_cycles, accel_stuck} !== {1'b1, 2'b10, CNT_W'(TMO), 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_result: got done=%b status=%b cycles=%0d stuck=%b expected 1 10 %0d 1",
               run_done, run_status, run_cycles, accel_stuck, TMO);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({ld_ready, rd_ready, accel_stuck} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL stuck_ready: got ld=%b rd=%b stuck=%b expected 0 0 1", ld_ready, rd_ready, accel_stuck);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({run_status, run_cycles, accel_stuck, run_done} !== '0) begin
      errors++;
      $display("[TB] FAIL stuck_reset: got status=%b cycles=%0d stuck=%b expected 00 0 0", run_status, run_cycles, accel_stuck);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ld_ready, rd_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL stuck_release: got %b expected 11", {ld_ready, rd_ready});
    end
  endtask
`else
  task automatic test_no_timeout();
    do_load(7'($urandom), 8'($urandom), 1'b1, 1);
    do_run(TMO * 3);
  endtask
`endif

  task automatic test_reset_mid_wr();
    ld_valid = 1; ld_addr = 7'h55; ld_data = 8'h99; ld_last = 1;
    @(posedge clock);
    @(negedge clock);
    ld_valid = 0; ld_last = 0;
    checks++;
    if (S_we_ram !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midwr_active: got we=%b expected 01", S_we_ram);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port} !== '0) begin
      errors++;
      $display("[TB] FAIL midwr_reset: got we=%b addr=%h wdata=%h size=%h expected all 0",
               S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({ld_ready, S_we_ram, start_port} !== {1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midwr_release: got ld_ready=%b we=%b start=%b expected 1 00 0", ld_ready, S_we_ram, start_port);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_delayed_loads();
    test_read_after_run();
    test_simultaneous();
    test_random();
`ifdef RUN_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
